hazard_ctrl: RTL

Pipeline stall/flush controller for the 5-stage LC-3b pipeline. It sits between the IF/ID and ID/EX stages, directly upstream of the EX-stage forwarding unit. It resolves the hazards forwarding cannot fix: load-use RAW (one bubble inserted, after which MEM/WB forwarding supplies the value), split-memory wait stalls, and taken-branch flushes. It drives the load enables of the PC and all four pipeline registers.

---
 rtl/hazard_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage LC-3b pipeline: load-use bubbles, split-memory waits, taken-branch flushes.
// Optional performance counters are built when HAZARD_PERF_EN is defined; otherwise they read as zero.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       IF_ID_sr1,
    input  logic [2:0]       IF_ID_sr2,
    input  logic             IF_ID_uses_sr1,
    input  logic             IF_ID_uses_sr2,
    input  logic [2:0]       ID_EX_dest,
    input  logic             ID_EX_write,
    input  logic             ID_EX_mem_read,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             branch_taken,
    input  logic             perf_clear,
    output logic             pc_load,
    output logic             IF_ID_load,
    output logic             ID_EX_load,
    output logic             EX_MEM_load,
    output logic             MEM_WB_load,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] MODE_RESET = 3'd0;
    localparam logic [2:0] MODE_WAIT  = 3'd1;
    localparam logic [2:0] MODE_FLUSH = 3'd2;
    localparam logic [2:0] MODE_LU    = 3'd3;
    localparam logic [2:0] MODE_RUN   = 3'd4;

    logic       imem_done_q, imem_done_d;
    logic       dmem_done_q, dmem_done_d;
    logic       lu_done_q, lu_done_d;
    logic       imem_ok_s, dmem_ok_s, advance_s, load_use_s;
    logic       sr1_hit_s, sr2_hit_s;
    logic [2:0] mode_s;

    assign imem_ok_s = !imem_read | imem_resp | imem_done_q;
    assign dmem_ok_s = !dmem_req  | dmem_resp | dmem_done_q;
    assign advance_s = imem_ok_s & dmem_ok_s;

    assign sr1_hit_s  = IF_ID_uses_sr1 & (ID_EX_dest == IF_ID_sr1);
    assign sr2_hit_s  = IF_ID_uses_sr2 & (ID_EX_dest == IF_ID_sr2);
    assign load_use_s = ID_EX_mem_read & ID_EX_write & (sr1_hit_s | sr2_hit_s);

    // Cycle classification; memory wait dominates, then branch flush, then load-use.
    always_comb begin
        mode_s = MODE_RUN;
        if (reset) begin
            mode_s = MODE_RESET;
        end else if (!advance_s) begin
            mode_s = MODE_WAIT;
        end else if (branch_taken) begin
            mode_s = MODE_FLUSH;
        end else if (load_use_s && !lu_done_q) begin
            mode_s = MODE_LU;
        end else begin
            mode_s = MODE_RUN;
        end
    end

    // Load enables, bubble and flush decode for the current cycle.
    always_comb begin
        pc_load      = 1'b0;
        IF_ID_load   = 1'b0;
        ID_EX_load   = 1'b0;
        EX_MEM_load  = 1'b0;
        MEM_WB_load  = 1'b0;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        case (mode_s)
            MODE_RESET, MODE_WAIT: begin
                pc_load = 1'b0;
            end
            MODE_FLUSH: begin
                pc_load      = 1'b1;
                IF_ID_load   = 1'b1;
                ID_EX_load   = 1'b1;
                EX_MEM_load  = 1'b1;
                MEM_WB_load  = 1'b1;
                IF_ID_flush  = 1'b1;
                ID_EX_flush  = 1'b1;
                EX_MEM_flush = 1'b1;
            end
            MODE_LU: begin
                ID_EX_load   = 1'b1;
                ID_EX_bubble = 1'b1;
                EX_MEM_load  = 1'b1;
                MEM_WB_load  = 1'b1;
            end
            MODE_RUN: begin
                pc_load     = 1'b1;
                IF_ID_load  = 1'b1;
                ID_EX_load  = 1'b1;
                EX_MEM_load = 1'b1;
                MEM_WB_load = 1'b1;
            end
            default: begin
                pc_load = 1'b0;
            end
        endcase
    end

    // Remember a response that arrived while the other memory side was still busy.
    always_comb begin
        imem_done_d = imem_done_q;
        dmem_done_d = dmem_done_q;
        lu_done_d   = lu_done_q;
        case (mode_s)
            MODE_RESET: begin
                imem_done_d = 1'b0;
                dmem_done_d = 1'b0;
                lu_done_d   = 1'b0;
            end
            MODE_WAIT: begin
                imem_done_d = imem_done_q | (imem_read & imem_resp);
                dmem_done_d = dmem_done_q | (dmem_req & dmem_resp);
            end
            MODE_LU: begin
                imem_done_d = 1'b0;
                dmem_done_d = 1'b0;
                lu_done_d   = 1'b1;
            end
            MODE_FLUSH, MODE_RUN: begin
                imem_done_d = 1'b0;
                dmem_done_d = 1'b0;
                lu_done_d   = 1'b0;
            end
            default: begin
                imem_done_d = 1'b0;
                dmem_done_d = 1'b0;
                lu_done_d   = 1'b0;
            end
        endcase
    end

    // Hazard flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
            lu_done_q   <= 1'b0;
        end else begin
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
            lu_done_q   <= lu_done_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        if (&v) begin
            return v;
        end else begin
            return v + one;
        end
    endfunction

    // Saturating increments for the stall/flush cycle just classified.
    always_comb begin
        lu_cnt_d    = lu_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (mode_s)
            MODE_LU:    lu_cnt_d    = sat_inc(lu_cnt_q);
            MODE_WAIT:  mem_cnt_d   = sat_inc(mem_cnt_q);
            MODE_FLUSH: flush_cnt_d = sat_inc(flush_cnt_q);
            default:    lu_cnt_d    = lu_cnt_q;
        endcase
    end

    // Counter registers; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || perf_clear) begin
            lu_cnt_q    <= {CNT_W{1'b0}};
            mem_cnt_q   <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            lu_cnt_q    <= lu_cnt_d;
            mem_cnt_q   <= mem_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign lu_stall_cnt  = lu_cnt_q;
    assign mem_stall_cnt = mem_cnt_q;
    assign flush_cnt     = flush_cnt_q;
`else
    logic unused_perf_clear_s;
    assign unused_perf_clear_s = perf_clear;

    assign lu_stall_cnt  = {CNT_W{1'b0}};
    assign mem_stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt     = {CNT_W{1'b0}};
`endif

endmodule
